// File: rtl/ram_fifo_ctrl_out_buf.sv
// ---------------------------------------------------------------------------
// fifo_out_buf
//   Two-entry output FIFO that absorbs the one-cycle read latency of ram_mem.
//   Entry 0 is always the head, so out_data_o needs no read mux.
//
// Ports
//   clk          in   clock, all state changes on posedge
//   rst          in   synchronous active-high reset (drops all entries)
//   push_i       in   capture push_data_i this cycle
//   push_data_i  in   word returned by the RAM
//   pop_i        in   consumer takes the head this cycle (only while valid)
//   out_valid_o  out  head entry holds a word
//   out_data_o   out  head entry
//   cnt_o        out  entries held, 0..2
// ---------------------------------------------------------------------------
module fifo_out_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            cnt_o
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = push_data_i;
                else               ent1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Pop and push together: the count holds, the new word lands
                // behind whatever survives the pop.
                if (cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data_i;
                end else begin
                    ent0_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 2'd0;
        else     cnt_q <= cnt_d;
    end

    // NOTE: the data entries are deliberately not reset; cnt_q alone decides validity.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = ent0_q;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   Turns a single-port ram_mem (registered address, one-cycle read latency)
//   into a valid/ready FIFO of DEPTH = 2**ADDR_WIDTH words. Writes and reads
//   share the RAM port; a 2-entry output buffer hides the read latency.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     write handshake, in_data is the word
//   out_valid/out_ready   read handshake, out_data is the oldest word
//   count                 words held (RAM + in-flight read + output buffer)
//   full / empty          occupancy flags
//   mem_we/addr/data      drive ram_mem; mem_q is its read data
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q, rd_pend_d;

    logic [1:0] ob_cnt;
    logic [2:0] credit;
    logic       pop, urgent, wr_go, rd_elig, rd_go;

    fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_pend_q),
        .push_data_i (mem_q),
        .pop_i       (pop),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .cnt_o       (ob_cnt)
    );

    assign pop = out_valid & out_ready;

    // The output is starving: words sit in the RAM but nothing is buffered or
    // in flight. Built from registered terms only, so in_ready never looks at
    // in_valid.
    assign urgent   = (mem_cnt_q != '0) & ~rd_pend_q & (ob_cnt == 2'd0);
    assign in_ready = ~rst & ~full & ~urgent;
    assign wr_go    = in_valid & in_ready;

    // Credit rule: only issue a read if the buffer will still have room when
    // the data comes back, which caps the buffer at two entries.
    assign credit  = {1'b0, ob_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_elig = (mem_cnt_q != '0) & (credit <= 3'd1);
    assign rd_go   = rd_elig & ~wr_go;

    assign mem_we   = wr_go;
    assign mem_addr = wr_go ? wr_ptr_q : rd_ptr_q;
    assign mem_data = in_data;

    assign count = mem_cnt_q + CNT_W'(rd_pend_q) + CNT_W'(ob_cnt);
    assign empty = (count == '0);
    // Capacity is counted over everything held, so the FIFO stores exactly
    // DEPTH words; the two buffered words keep the RAM itself from filling.
    assign full  = (count == CNT_W'(DEPTH));

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        // mem_q is only valid the cycle after a read, so the pending flag
        // lives exactly one cycle unless another read follows.
        rd_pend_d = rd_go;
        if (wr_go) begin
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end else if (rd_go) begin
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
            mem_cnt_d = mem_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//   Directed bench for ram_fifo_ctrl with a behavioural ram_mem beside it.
//   Accepted words go into a scoreboard queue; each output handshake pops
//   the queue and compares. A shadow count tracks words held.
// ---------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;

    int            n_cmp = 0;
    int            n_err = 0;
    int            mcnt  = 0;
    logic [DW-1:0] sb[$];
    logic          rand_stall;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_q     (mem_q)
    );

    // Behavioural ram_mem: address re-registered every cycle, read after write.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        ram_addr_q <= mem_addr;
    end
    assign mem_q = ram[ram_addr_q];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge: inputs are stable, so the handshakes seen
    // here are the ones the DUT takes at the next rising edge.
    always @(negedge clk) begin
        logic          in_fire, out_fire;
        logic [DW-1:0] exp_word;
        if (rst === 1'b1) begin
            check("in_ready_in_reset", in_ready, 1'b0);
            sb.delete();
            mcnt = 0;
        end else if (rst === 1'b0) begin
            in_fire  = in_valid & in_ready;
            out_fire = out_valid & out_ready;
            check("count", count, mcnt);
            check("empty", empty, (mcnt == 0));
            check("full", full, (mcnt == DEPTH));
            check("port_conflict", mem_we & dut.rd_go, 1'b0);
            check("ob_cnt_le2", (dut.ob_cnt <= 2'd2), 1'b1);
            if (out_fire) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 1'b1, 1'b0);
                end else begin
                    exp_word = sb.pop_front();
                    check("out_data", out_data, exp_word);
                end
            end
            if (in_fire) sb.push_back(in_data);
            mcnt = mcnt + int'(in_fire) - int'(out_fire);
        end
    end

    // Called and returning just after a rising edge.
    task automatic push(input logic [DW-1:0] d);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_stall) out_ready = 1'($urandom_range(0, 1));
            if (ok) break;
        end
        in_valid = 1'b0;
        check("push_accepted", ok, 1'b1);
    endtask

    task automatic drain();
        logic ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        rand_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 1: single word latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        @(negedge clk);
        check("t1_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat_edge1", out_valid, 1'b0);
        @(negedge clk);
        check("t1_lat_edge2", out_valid, 1'b0);
        @(negedge clk);
        check("t1_lat_edge3", out_valid, 1'b1);
        check("t1_data", out_data, 8'hA5);
        @(negedge clk);
        check("t1_count", count, 0);
        check("t1_empty", empty, 1'b1);
        @(posedge clk);
        #1;

        // 2: fill to DEPTH with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(DW'(i));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        check("t2_count", count, DEPTH);
        check("t2_full", full, 1'b1);
        check("t2_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_in_ready_hold", in_ready, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // 3: drain at full rate, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("t3_no_gap", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_count", count, 0);
        check("t3_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // 4: continuous traffic both sides
        out_ready = 1'b1;
        for (int i = 0; i < 150; i++) push(DW'($urandom_range(0, 255)));
        drain();

        // 5: random consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 150; i++) push(DW'($urandom_range(0, 255)));
        rand_stall = 1'b0;
        drain();

        // 6: reset with 10 words held and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) push(DW'(8'h40 + i));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_count_before_pop", count, 11);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("t6_count_at_rst", count, 10);
        check("t6_rd_in_flight", dut.rd_pend_q, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_count_after_rst", count, 0);
        check("t6_out_valid_after_rst", out_valid, 1'b0);
        check("t6_empty_after_rst", empty, 1'b1);
        @(posedge clk);
        #1;
        push(8'h11);
        push(8'h22);
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
